// File: rtl/water_column_n.sv
// Water-column level display controller: one level register drives LINES 2-bit thermometer segments.
// Optional sticky boundary-request alarm is enabled with the WATER_ALARM_EN macro.
module water_column_n #(
    parameter int LINES = 7,
    parameter int DIV   = 4
) (
    input  logic                           clk,
    input  logic                           init,
    input  logic                           run,
    input  logic                           mode,
    output logic [2*LINES-1:0]             lines,
    output logic [$clog2(2*LINES+1)-1:0]   level,
    output logic                           full,
    output logic                           empty,
    output logic                           busy,
    output logic                           alarm
);

    localparam int LW = $clog2(2*LINES+1);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [LW-1:0] LVL_MAX  = LW'(2*LINES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   lvl_inc, lvl_dec;

    assign lvl_inc = level_q + LW'(1);
    assign lvl_dec = level_q - LW'(1);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!run) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode && !full) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else if (!mode && !empty) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
                FILL: begin
                    // A reversal restarts the divider without moving the level.
                    if (!mode) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = '0;
                        if (level_q != LVL_MAX) level_d = lvl_inc;
                        if (level_q == LVL_MAX || lvl_inc == LVL_MAX) state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (mode) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = '0;
                        if (level_q != '0) level_d = lvl_dec;
                        if (level_q == '0 || lvl_dec == '0) state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        lines = '0;
        for (int k = 0; k < LINES; k++) begin
            if (int'(level_q) >= 2*k+2)       lines[2*k +: 2] = 2'b11;
            else if (int'(level_q) == 2*k+1)  lines[2*k +: 2] = 2'b01;
        end
    end

    assign level = level_q;
    assign full  = (level_q == LVL_MAX);
    assign empty = (level_q == '0);
    assign busy  = (state_q != IDLE);

`ifdef WATER_ALARM_EN
    logic alarm_q, alarm_d;

    // Any level movement clears the flag; a refused boundary request sets it.
    always_comb begin
        alarm_d = alarm_q;
        if (level_d != level_q)
            alarm_d = 1'b0;
        else if (state_q == IDLE && run && ((mode && full) || (!mode && empty)))
            alarm_d = 1'b1;
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) alarm_q <= 1'b0;
        else      alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_water_column_n.sv
// Directed bench for water_column_n: four parameterisations share clock and inputs,
// a vector table covers the full fill, hand sequences cover reset, drain, reversal, run drop, alarm.
module tb_water_column_n;

    logic clk = 1'b0;
    logic init = 1'b1;
    logic run = 1'b0;
    logic mode = 1'b0;

    logic [5:0] lines_a, lines_b, lines_c;
    logic [3:0] lines_d;
    logic [2:0] level_a, level_b, level_c, level_d;
    logic full_a, full_b, full_c, full_d;
    logic empty_a, empty_b, empty_c, empty_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic alarm_a, alarm_b, alarm_c, alarm_d;

`ifdef WATER_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif

    always #5 clk = ~clk;

    water_column_n #(.LINES(3), .DIV(2)) u_a (
        .clk(clk), .init(init), .run(run), .mode(mode), .lines(lines_a), .level(level_a),
        .full(full_a), .empty(empty_a), .busy(busy_a), .alarm(alarm_a));
    water_column_n #(.LINES(3), .DIV(1)) u_b (
        .clk(clk), .init(init), .run(run), .mode(mode), .lines(lines_b), .level(level_b),
        .full(full_b), .empty(empty_b), .busy(busy_b), .alarm(alarm_b));
    water_column_n #(.LINES(3), .DIV(4)) u_c (
        .clk(clk), .init(init), .run(run), .mode(mode), .lines(lines_c), .level(level_c),
        .full(full_c), .empty(empty_c), .busy(busy_c), .alarm(alarm_c));
    water_column_n #(.LINES(2), .DIV(1)) u_d (
        .clk(clk), .init(init), .run(run), .mode(mode), .lines(lines_d), .level(level_d),
        .full(full_d), .empty(empty_d), .busy(busy_d), .alarm(alarm_d));

    typedef struct {
        int         lvl;
        logic [5:0] ln;
        logic       full;
        logic       empty;
        logic       busy;
    } vec_t;

    vec_t tbl[14];
    logic [5:0] drain_seq[7];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init = 1'b1;
        run  = 1'b0;
        mode = 1'b0;
        #2;
        init = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full fill, LINES=3 DIV=2: one row per edge starting at edge E.
        tbl[0]  = '{0, 6'b000000, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{0, 6'b000000, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1, 6'b000001, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1, 6'b000001, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2, 6'b000011, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2, 6'b000011, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3, 6'b000111, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3, 6'b000111, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4, 6'b001111, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4, 6'b001111, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{5, 6'b011111, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{5, 6'b011111, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{6, 6'b111111, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{6, 6'b111111, 1'b1, 1'b0, 1'b0};
        drain_seq[0] = 6'b111111; drain_seq[1] = 6'b011111; drain_seq[2] = 6'b001111;
        drain_seq[3] = 6'b000111; drain_seq[4] = 6'b000011; drain_seq[5] = 6'b000001;
        drain_seq[6] = 6'b000000;

        // Reset values with init held and no edge yet.
        #2;
        chk("rst_level", int'(level_a), 0);
        chk("rst_lines", int'(lines_a), 0);
        chk("rst_empty", int'(empty_a), 1);
        chk("rst_full", int'(full_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_alarm", int'(alarm_d), 0);
        chk("rst_lines_d", int'(lines_d), 0);
        #1;
        init = 1'b0;
        run  = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("fill%0d_level", i), int'(level_a), tbl[i].lvl);
            chk($sformatf("fill%0d_lines", i), int'(lines_a), int'(tbl[i].ln));
            chk($sformatf("fill%0d_full", i), int'(full_a), int'(tbl[i].full));
            chk($sformatf("fill%0d_empty", i), int'(empty_a), int'(tbl[i].empty));
            chk($sformatf("fill%0d_busy", i), int'(busy_a), int'(tbl[i].busy));
        end

        // Reset mid-fill: asynchronous clear between edges.
        do_reset();
        run  = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 20 && level_a != 3'd3; i++) tick();
        chk("midfill_reach", int'(level_a), 3);
        #2;
        init = 1'b1;
        #1;
        chk("midfill_level", int'(level_a), 0);
        chk("midfill_lines", int'(lines_a), 0);
        chk("midfill_empty", int'(empty_a), 1);
        chk("midfill_busy", int'(busy_a), 0);
        run = 1'b0;
        #1;
        init = 1'b0;

        // Drain from full, DIV=1.
        do_reset();
        run  = 1'b1;
        mode = 1'b1;
        repeat (7) tick();
        chk("b_full_level", int'(level_b), 6);
        chk("b_full_busy", int'(busy_b), 0);
        mode = 1'b0;
        tick();
        chk("drain0_lines", int'(lines_b), int'(drain_seq[0]));
        chk("drain0_busy", int'(busy_b), 1);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("drain%0d_lines", i), int'(lines_b), int'(drain_seq[i]));
        end
        chk("drain_empty", int'(empty_b), 1);
        chk("drain_busy", int'(busy_b), 0);

        // Reversal at cnt=2 with DIV=4.
        do_reset();
        run  = 1'b1;
        mode = 1'b1;
        repeat (13) tick();
        chk("rev_pre_level", int'(level_c), 3);
        chk("rev_pre_busy", int'(busy_c), 1);
        repeat (2) tick();
        chk("rev_cnt2_level", int'(level_c), 3);
        mode = 1'b0;
        tick();
        chk("rev_edge_level", int'(level_c), 3);
        repeat (3) tick();
        chk("rev_plus3_level", int'(level_c), 3);
        tick();
        chk("rev_plus4_level", int'(level_c), 2);
        chk("rev_plus4_busy", int'(busy_c), 1);

        // Run drop at cnt=3 during fill, then a full-length step on re-enable.
        mode = 1'b1;
        tick();
        repeat (3) tick();
        chk("drop_pre_level", int'(level_c), 2);
        run = 1'b0;
        tick();
        chk("drop_level", int'(level_c), 2);
        chk("drop_busy", int'(busy_c), 0);
        run = 1'b1;
        tick();
        chk("reen_busy", int'(busy_c), 1);
        repeat (3) tick();
        chk("reen_plus3_level", int'(level_c), 2);
        tick();
        chk("reen_plus4_level", int'(level_c), 3);

        // Alarm on a refused fill request, LINES=2.
        do_reset();
        run  = 1'b1;
        mode = 1'b1;
        repeat (5) tick();
        chk("al_full_level", int'(level_d), 4);
        chk("al_full_flag", int'(full_d), 1);
        chk("al_before", int'(alarm_d), 0);
        tick();
        chk("al_set", int'(alarm_d), ALARM_ON);
        chk("al_set_busy", int'(busy_d), 0);
        run = 1'b0;
        repeat (2) tick();
        chk("al_hold", int'(alarm_d), ALARM_ON);
        run  = 1'b1;
        mode = 1'b0;
        tick();
        chk("al_drain_start", int'(alarm_d), ALARM_ON);
        chk("al_drain_start_level", int'(level_d), 4);
        tick();
        chk("al_step_level", int'(level_d), 3);
        chk("al_cleared", int'(alarm_d), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
